// File: rtl/inst_sram_resp.sv
// Instruction-memory responder: one fetch at a time, word returned after LATENCY cycles and held until taken.
// Optional INST_SRAM_FAULT_EN adds rsp_err for misaligned or out-of-window fetches.
module inst_sram_resp #(
  parameter int                      ADDR_WIDTH  = 32,
  parameter int                      DATA_WIDTH  = 32,
  parameter int                      DEPTH_WORDS = 4096,
  parameter logic [ADDR_WIDTH-1:0]   BASE_ADDR   = 32'h80000000,
  parameter int                      LATENCY     = 1,
  parameter logic [DATA_WIDTH-1:0]   IDLE_INST   = 32'h00000013
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  req_ready,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_inst,
  input  logic                  rsp_ready,
  input  logic                  ld_en,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  input  logic [DATA_WIDTH-1:0] ld_data
`ifdef INST_SRAM_FAULT_EN
  ,
  output logic                  rsp_err
`endif
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;

  // Handshakes: a request transfers on an edge where req_valid && req_ready;
  // a response transfers on an edge where rsp_valid && rsp_ready. Either side may
  // raise valid independently; ready never depends on the partner's valid.
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [DATA_WIDTH-1:0]  inst_q;
  logic                   load_rsp;
  logic [IDX_W-1:0]       req_idx, ld_idx, rd_idx;
  logic [DATA_WIDTH-1:0]  mem_q [DEPTH_WORDS];

  // Offset is taken modulo 2^ADDR_WIDTH, so addresses outside the window alias.
  function automatic logic [ADDR_WIDTH-1:0] to_offset(input logic [ADDR_WIDTH-1:0] a);
    return a - BASE_ADDR;
  endfunction

  function automatic logic [IDX_W-1:0] to_index(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] off;
    off = to_offset(a);
    return off[IDX_W+1:2];
  endfunction

  assign req_idx = to_index(req_addr);
  assign ld_idx  = to_index(ld_addr);
  assign rd_idx  = (state_q == S_IDLE) ? req_idx : idx_q;

`ifdef INST_SRAM_FAULT_EN
  logic fault_q, fault_d, req_fault, rd_fault;
  logic [ADDR_WIDTH-1:0] req_off;

  assign req_off   = to_offset(req_addr);
  assign req_fault = (req_addr[1:0] != 2'b00) || ((req_off >> (IDX_W + 2)) != '0);
  assign rd_fault  = (state_q == S_IDLE) ? req_fault : fault_q;
  assign fault_d   = (state_q == S_IDLE && req_valid) ? req_fault : fault_q;
  assign rsp_err   = rsp_valid && fault_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) fault_q <= 1'b0;
    else     fault_q <= fault_d;
  end
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    load_rsp = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          idx_d = req_idx;
          if (LATENCY == 1) begin
            state_d  = S_RESP;
            load_rsp = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_W'(LATENCY - 2);
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d  = S_RESP;
          load_rsp = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The word is captured on the edge that enters RESP; a same-edge sideband
  // write lands afterwards, so the response carries the old contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      inst_q  <= IDLE_INST;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      if (load_rsp) begin
`ifdef INST_SRAM_FAULT_EN
        inst_q <= rd_fault ? '0 : mem_q[rd_idx];
`else
        inst_q <= mem_q[rd_idx];
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ld_en) mem_q[ld_idx] <= ld_data;
  end

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_inst  = rsp_valid ? inst_q : IDLE_INST;

endmodule

// File: doc/inst_sram_resp.md
Name: inst_sram_resp

Overview:
- Instruction-memory responder: the memory end of the fetch interface that the core drives with a pc and consumes an instruction from.
- Accepts one fetch request (address) at a time over a valid/ready handshake.
- Returns the 32-bit word after a programmable latency, holding it until the core takes it.
- Backing store is an internal word array, preloaded through a sideband write port from the bench or loader.

Parameters:
- ADDR_WIDTH, 32: request address width in bits.
- DATA_WIDTH, 32: instruction word width in bits.
- DEPTH_WORDS, 4096: number of words in the array; must be a power of two.
- BASE_ADDR, 32'h80000000: byte address of word 0.
- LATENCY, 1: cycles from request acceptance to rsp_valid; must be ≥1.
- IDLE_INST, 32'h00000013: value driven on rsp_inst whenever rsp_valid=0 (nop).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  fetch request present.
- req_addr  in  ADDR_WIDTH  fetch byte address (pc).
- req_ready  out  1  responder can accept a request.
- rsp_valid  out  1  rsp_inst holds returned word.
- rsp_inst  out  DATA_WIDTH  returned instruction.
- rsp_ready  in  1  core consumes response.
- ld_en  in  1  sideband array write enable.
- ld_addr  in  ADDR_WIDTH  sideband byte address.
- ld_data  in  DATA_WIDTH  sideband write data.

Behaviour:
- Reset (async assert, synchronous-to-clk deassert use):
  - state=IDLE, req_ready=1, rsp_valid=0, rsp_inst=IDLE_INST, latency counter=0.
  - Array contents are not cleared.
- Index = ((addr − BASE_ADDR) >> 2) truncated to log2(DEPTH_WORDS) bits. Subtraction is modulo 2^ADDR_WIDTH, so out-of-range addresses alias. addr[1:0] is ignored.
- States:
  - IDLE: req_ready=1. On req_valid&req_ready, latch the index. Go to RESP if LATENCY==1, else go to WAIT with counter=LATENCY−2.
  - WAIT: req_ready=0. Counter decrements each cycle. At 0, go to RESP.
  - RESP: rsp_valid=1, req_ready=0. rsp_inst is the array word sampled on the clock edge that entered RESP. It is held stable until rsp_ready=1. On rsp_valid&rsp_ready, return to IDLE next cycle.
- Timing:
  - A request accepted at edge T produces rsp_valid=1 from edge T+LATENCY onward.
  - Minimum request-to-request spacing is LATENCY+1 cycles.
- req_addr and req_valid are ignored outside IDLE. A request held through WAIT/RESP is not double-accepted.
- Sideband write:
  - ld_en writes ld_data at index(ld_addr) on posedge, in any state.
  - If a write hits the same index on the same edge the read is sampled, the response carries the old word.
- rsp_ready asserted while rsp_valid=0 has no effect.
- Reset asserted mid-WAIT or mid-RESP aborts the transaction immediately. No response is delivered after reset release.

Optional Feature:
- Macro: INST_SRAM_FAULT_EN.
- Defined:
  - Adds port rsp_err (out, 1), reset 0, valid only with rsp_valid.
  - rsp_err=1 and rsp_inst=0 when req_addr[1:0]!=0 or req_addr is outside [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS).
  - Latency and handshake are unchanged.
- Undefined: no rsp_err port; addresses alias as above and misalignment is ignored.

Test Plan:
- Reset: assert rst mid-cycle without a clock edge → req_ready=1, rsp_valid=0, rsp_inst=32'h00000013 immediately.
- Basic fetch, LATENCY=1:
  - Stimulus: load word 32'h00100093 at 32'h80000000; request 32'h80000000 with rsp_ready=1.
  - Response: rsp_valid exactly one cycle after accept, rsp_inst=32'h00100093, back in IDLE the next cycle.
- Latency and back-pressure, LATENCY=3:
  - Stimulus: request 32'h80000004 (loaded with 32'h00000073); hold rsp_ready=0 for 5 cycles.
  - Response: rsp_valid at accept+3; rsp_inst stays stable for all 5 cycles; req_ready stays 0 until the cycle after the rsp_ready handshake.
- Read/write collision:
  - Stimulus: word 32'hAAAA_AAAA at index 2; LATENCY=1; request 32'h80000008 and ld_en to the same address with 32'h5555_5555 on the sampling edge.
  - Response: rsp_inst=32'hAAAA_AAAA; a following fetch returns 32'h5555_5555.
- Reset mid-operation, LATENCY=4:
  - Stimulus: accept a request, assert rst during WAIT, release rst.
  - Response: rsp_valid never rises for the aborted request; a new request completes normally; array contents are preserved.
- Wrap and fault:
  - Stimulus: request 32'h80004000 with DEPTH_WORDS=4096.
  - Response, without INST_SRAM_FAULT_EN: returns word 0.
  - Response, with INST_SRAM_FAULT_EN: rsp_err=1, rsp_inst=0; request 32'h80000002 also gives rsp_err=1.
